branch_perf_counters: RTL

Synthesizable performance-counter block inside the CPU that owns the counting of branch-predictor statistics: cycles, retired instructions, branches, mispredictions, repeat-misses, per-confidence misses and stalls. It sits beside the BATAGE predictor and pipeline. Software or a bench reads its counters through a request/acknowledge register-read port, so no hierarchical probing is needed. It is the responder end of the performance-statistics read path.

---
 rtl/branch_perf_counters.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_perf_counters.sv
// -----------------------------------------------------------------------------
// branch_perf_counters
//
// Branch-predictor statistics counters with a request/acknowledge read port.
// The block counts cycles, retired instructions, decoded branches,
// mispredictions, repeat-misses, mispredictions split by confidence, and
// stalls. Every counter saturates at all-ones and then sets a sticky overflow
// flag. The flags are read back together as the STATUS word.
//
// Counter map (rd_addr):
//   0 CYCLES       1 INSTRET     2 BRANCHES    3 MISPRED     4 MISS_REPEAT
//   5 MISS_CONF0   6 MISS_CONF1  7 MISS_CONF2  8 STALLS
//   9 STATUS (overflow flag k in bit k)        10-15 read as zero
//
// Ports:
//   clk           rising-edge clock
//   rst_BF_n      synchronous active-low reset
//   id_valid      decode-stage instruction valid
//   id_inst       decode-stage instruction word (opcode in [6:0])
//   retire_valid  one instruction retired this cycle
//   flush         misprediction flush, one-cycle pulse per miss
//   flush_inst    instruction word of the mispredicted branch
//   conf          predictor confidence of the mispredicted branch
//   stall         pipeline stall this cycle
//   freeze        suppress all increments while high
//   clr           clear all counters and overflow flags
//   rd_req        read request (level)
//   rd_addr       counter select, latched when the request is accepted
//   rd_ack        one-cycle read-data-valid pulse
//   rd_data       read data, held until the next acknowledge
// -----------------------------------------------------------------------------
module branch_perf_counters #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MISS_DIST = 4
) (
  input  logic             clk,
  input  logic             rst_BF_n,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             retire_valid,
  input  logic             flush,
  input  logic [31:0]      flush_inst,
  input  logic [1:0]       conf,
  input  logic             stall,
  input  logic             freeze,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [3:0]       rd_addr,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data
);

  localparam int NUM_CNT = 9;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Control-transfer opcodes: conditional branch, JAL, JALR.
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ADDR_STATUS = 4'd9;
  localparam logic [3:0] ADDR_LAST  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ACK,
    ST_WAIT
  } rd_state_e;

  logic [CNT_W-1:0]         cnt_q [NUM_CNT];
  logic [NUM_CNT-1:0]       ovf_q;
  logic [NUM_CNT-1:0]       inc;

  logic [MISS_DIST-1:0]     flush_hist_q;
  logic [31:0]              inst_hist_q [MISS_DIST];
  logic                     repeat_miss;

  rd_state_e                state_q;
  rd_state_e                state_d;
  logic [3:0]               rd_addr_q;
  logic [CNT_W-1:0]         rd_data_q;
  logic [CNT_W-1:0]         sel_value;
  logic [CNT_W+NUM_CNT-1:0] status_wide;

  // Only the opcode field classifies an instruction as a branch.
  logic unused_inst_bits;
  assign unused_inst_bits = ^id_inst[31:7];

  // ---------------------------------------------------------------------------
  // Flush history: oldest entry sits at index MISS_DIST-1, so it holds the
  // flush seen exactly MISS_DIST cycles ago. It shifts every cycle, even while
  // frozen or clearing. Flushes in between do not affect the match.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours. The shift chain depends on
    // that.
    if (!rst_BF_n) begin
      flush_hist_q <= '0;
      // NOTE: this history array is a small register file, not RAM. It is
      // reset explicitly so a stale instruction word cannot fake a repeat
      // after reset.
      for (int i = 0; i < int'(MISS_DIST); i++) begin
        inst_hist_q[i] <= '0;
      end
    end else begin
      flush_hist_q[0] <= flush;
      inst_hist_q[0]  <= flush_inst;
      for (int i = 1; i < int'(MISS_DIST); i++) begin
        flush_hist_q[i] <= flush_hist_q[i-1];
        inst_hist_q[i]  <= inst_hist_q[i-1];
      end
    end
  end

  assign repeat_miss = flush && flush_hist_q[MISS_DIST-1]
                       && (flush_inst == inst_hist_q[MISS_DIST-1]);

  // ---------------------------------------------------------------------------
  // Per-counter increment requests
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default every always_comb output first, so no path leaves it
    // unassigned and infers a latch.
    inc    = '0;
    inc[0] = 1'b1;
    inc[1] = retire_valid;
    inc[2] = id_valid && ((id_inst[6:0] == OP_BRANCH) ||
                          (id_inst[6:0] == OP_JAL)    ||
                          (id_inst[6:0] == OP_JALR));
    inc[3] = flush;
    inc[4] = repeat_miss;
    inc[5] = flush && (conf == 2'd0);
    inc[6] = flush && (conf == 2'd1);
    inc[7] = flush && (conf == 2'd2);
    inc[8] = stall;
  end

  // ---------------------------------------------------------------------------
  // Counters. Priority: reset > clr > freeze > increment. An increment at
  // all-ones leaves the counter unchanged and sets its overflow flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_BF_n || clr) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= '0;
      end
      ovf_q <= '0;
    end else if (!freeze) begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (inc[k]) begin
          if (cnt_q[k] == CNT_MAX) begin
            ovf_q[k] <= 1'b1;
          end else begin
            cnt_q[k] <= cnt_q[k] + CNT_ONE;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // When CNT_W is narrower than the flag vector, the upper flags are truncated.
  assign status_wide = {{CNT_W{1'b0}}, ovf_q};

  always_comb begin
    sel_value = '0;
    if (rd_addr_q <= ADDR_LAST) begin
      sel_value = cnt_q[rd_addr_q];
    end else if (rd_addr_q == ADDR_STATUS) begin
      sel_value = status_wide[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_BF_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rd_req) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_ACK;
      ST_ACK:     state_d = ST_WAIT;
      ST_WAIT:    if (!rd_req) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The capture samples cnt_q before this edge's update, so a clr in the
  // capture cycle still returns the pre-clear value.
  always_ff @(posedge clk) begin
    if (!rst_BF_n) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (state_q == ST_IDLE && rd_req) begin
        rd_addr_q <= rd_addr;
      end
      if (state_q == ST_CAPTURE) begin
        rd_data_q <= sel_value;
      end
    end
  end

  assign rd_ack  = (state_q == ST_ACK);
  assign rd_data = rd_data_q;

endmodule
